// File: rtl/mohan_mult_pkg.sv
// Shared constants and types for the mohan_multiplier shift-add multiplier.
package mohan_mult_pkg;

    localparam int unsigned WIDTH        = 8;
    localparam int unsigned PROD_W       = 2 * WIDTH;
    localparam int unsigned CYCLES       = WIDTH;
    localparam int unsigned CNT_W        = $clog2(CYCLES);

    localparam int unsigned LOAD_A_BIT   = 0;
    localparam int unsigned START_BIT    = 1;
    localparam int unsigned BYTE_SEL_BIT = 2;
    localparam int unsigned SIGNED_BIT   = 3;
    localparam int unsigned BUSY_BIT     = 6;
    localparam int unsigned DONE_BIT     = 7;

    localparam logic [7:0]  UIO_OE_VALUE = 8'hC0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mohan_mult_core.sv
// Sequential shift-add multiplier datapath: operands, accumulator, counter, status, result.
// SIGNED_MUL_EN adds a two's-complement mode applied as a correction on the final step.
module mohan_mult_core
    import mohan_mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              load_a,
    input  logic              start,
`ifdef SIGNED_MUL_EN
    input  logic              signed_mode,
`endif
    input  logic [WIDTH-1:0]  operand,
    output logic [PROD_W-1:0] result,
    output logic              busy,
    output logic              done
);

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   a_q, a_n;
    logic [WIDTH-1:0]   b_q, b_n;
    logic [PROD_W-1:0]  acc_q, acc_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [PROD_W-1:0]  result_n;
    logic               busy_n, done_n;
    logic [WIDTH:0]     sum;
    logic [PROD_W-1:0]  step;
    logic [PROD_W-1:0]  final_prod;
`ifdef SIGNED_MUL_EN
    logic               sgn_q, sgn_n;
    logic [WIDTH-1:0]   corr_hi;
`endif

    // State register; ena low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SIGNED_MUL_EN
            sgn_q   <= 1'b0;
`endif
        end else if (ena) begin
            state_q <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
            acc_q   <= acc_n;
            cnt_q   <= cnt_n;
            result  <= result_n;
            busy    <= busy_n;
            done    <= done_n;
`ifdef SIGNED_MUL_EN
            sgn_q   <= sgn_n;
`endif
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_n  = state_q;
        a_n      = a_q;
        b_n      = b_q;
        acc_n    = acc_q;
        cnt_n    = cnt_q;
        result_n = result;
        busy_n   = busy;
        done_n   = done;

        // One iteration: add A into the upper half when the multiplier bit is set, then shift right.
        sum  = {1'b0, acc_q[PROD_W-1:WIDTH]} + (b_q[cnt_q] ? {1'b0, a_q} : (WIDTH+1)'(0));
        step = {sum, acc_q[WIDTH-1:1]};

`ifdef SIGNED_MUL_EN
        sgn_n      = sgn_q;
        // Unsigned product minus 2^8 * (A if B negative, B if A negative) yields the signed product.
        corr_hi    = ((sgn_q && a_q[WIDTH-1]) ? b_q : WIDTH'(0))
                   + ((sgn_q && b_q[WIDTH-1]) ? a_q : WIDTH'(0));
        final_prod = step - {corr_hi, WIDTH'(0)};
`else
        final_prod = step;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n = S_BUSY;
                    b_n     = operand;
                    acc_n   = '0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
`ifdef SIGNED_MUL_EN
                    sgn_n   = signed_mode;
`endif
                end else if (load_a) begin
                    a_n = operand;
                end
            end
            S_BUSY: begin
                acc_n = step;
                cnt_n = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CYCLES - 1)) begin
                    state_n  = S_IDLE;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                    result_n = final_prod;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: rtl/mohan_multiplier.sv
// Tiny Tapeout top for the 8x8 sequential multiplier: pin mapping and product byte mux.
// Optional macro SIGNED_MUL_EN enables signed_mode on uio_in[3].
module mohan_multiplier
    import mohan_mult_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [PROD_W-1:0] result;
    logic              busy;
    logic              done;
    logic              unused_pins;

    mohan_mult_core u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .load_a      (uio_in[LOAD_A_BIT]),
        .start       (uio_in[START_BIT]),
`ifdef SIGNED_MUL_EN
        .signed_mode (uio_in[SIGNED_BIT]),
`endif
        .operand     (ui_in),
        .result      (result),
        .busy        (busy),
        .done        (done)
    );

`ifdef SIGNED_MUL_EN
    assign unused_pins = &{1'b0, uio_in[7:4]};
`else
    assign unused_pins = &{1'b0, uio_in[7:4], uio_in[SIGNED_BIT]};
`endif

    // Byte select is a live mux so a read can flip halves within one cycle.
    assign uo_out = uio_in[BYTE_SEL_BIT] ? result[PROD_W-1:WIDTH] : result[WIDTH-1:0];

    always_comb begin
        uio_out           = '0;
        uio_out[DONE_BIT] = done;
        uio_out[BUSY_BIT] = busy;
    end

    assign uio_oe = UIO_OE_VALUE;

endmodule

// File: tb/tb_mohan_multiplier.sv
// Self-checking bench for mohan_multiplier: vector table plus scoreboard queue of expected products.
module tb_mohan_multiplier;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          sgn;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_q[$];

    mohan_multiplier dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire done_w = uio_out[7];
    wire busy_w = uio_out[6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the load edge.
    task automatic load_a(input logic [7:0] a);
        ui_in  = a;
        uio_in = 8'h01;
        @(negedge clk);
        ui_in  = 8'h00;
        uio_in = 8'h00;
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic issue_start(input logic [7:0] b, input bit sgn, input logic [15:0] exp);
        ui_in  = b;
        uio_in = sgn ? 8'h0A : 8'h02;
        exp_q.push_back(exp);
        @(negedge clk);
        ui_in  = 8'h00;
        uio_in = 8'h00;
    endtask

    task automatic wait_done(input int from, output int cyc);
        cyc = from;
        while (!done_w && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Checks latency, status flags and both product bytes against the scoreboard head.
    task automatic check_result(input string name, input int cyc, input int exp_cyc);
        logic [15:0] e;
        check({name, " latency"}, 16'(cyc), 16'(exp_cyc));
        check({name, " flags"}, {8'h00, uio_out}, 16'h0080);
        if (exp_q.size() == 0) begin
            check({name, " scoreboard empty"}, 16'h0001, 16'h0000);
        end else begin
            e = exp_q.pop_front();
            uio_in = 8'h00;
            #1;
            check({name, " lo"}, {8'h00, uo_out}, {8'h00, e[7:0]});
            uio_in = 8'h04;
            #1;
            check({name, " hi"}, {8'h00, uo_out}, {8'h00, e[15:8]});
            uio_in = 8'h00;
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input bit sgn, input logic [15:0] exp);
        int cyc;
        load_a(a);
        issue_start(b, sgn, exp);
        wait_done(0, cyc);
        check_result(name, cyc, 8);
        @(negedge clk);
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input bit sgn);
        int pa, pb;
        pa = sgn ? int'($signed(a)) : int'(a);
        pb = sgn ? int'($signed(b)) : int'(b);
        return 16'(pa * pb);
    endfunction

    initial begin
        int cyc;
        logic [7:0] ra, rb;
        bit rs;

        vecs.push_back('{8'd12,  8'd13,  1'b0, 16'h009C});
        vecs.push_back('{8'd255, 8'd255, 1'b0, 16'hFE01});
        vecs.push_back('{8'd0,   8'd200, 1'b0, 16'h0000});
        vecs.push_back('{8'd200, 8'd0,   1'b0, 16'h0000});
        vecs.push_back('{8'd1,   8'd1,   1'b0, 16'h0001});
        vecs.push_back('{8'd128, 8'd2,   1'b0, 16'h0100});
        vecs.push_back('{8'd37,  8'd91,  1'b0, 16'h0D27});
        vecs.push_back('{8'hFF,  8'h02,  1'b0, 16'h01FE});
`ifdef SIGNED_MUL_EN
        vecs.push_back('{8'hFF,  8'h02,  1'b1, 16'hFFFE});
        vecs.push_back('{8'h80,  8'h80,  1'b1, 16'h4000});
        vecs.push_back('{8'h80,  8'h7F,  1'b1, 16'hC080});
        vecs.push_back('{8'h05,  8'hFD,  1'b1, 16'hFFF1});
`endif

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset state, held for 5 cycles.
        #2;
        check("reset uo_out lo", {8'h00, uo_out}, 16'h0000);
        uio_in = 8'h04;
        #1;
        check("reset uo_out hi", {8'h00, uo_out}, 16'h0000);
        uio_in = 8'h00;
        check("reset uio_out", {8'h00, uio_out}, 16'h0000);
        check("reset uio_oe", {8'h00, uio_oe}, 16'h00C0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset hold", {uo_out, uio_out}, 16'h0000);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp);

        // Random operands against the bench model.
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
`ifdef SIGNED_MUL_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op($sformatf("rand%0d", i), ra, rb, rs, model(ra, rb, rs));
        end

        // done persists while idle and the result holds.
        run_op("hold setup", 8'd4, 8'd4, 1'b0, 16'h0010);
        repeat (3) @(negedge clk);
        check("done persists", {8'h00, uio_out}, 16'h0080);
        check("result held", {8'h00, uo_out}, 16'h0010);

        // start and load_a during busy are ignored.
        load_a(8'd3);
        issue_start(8'd5, 1'b0, 16'h000F);
        check("busy after start", {8'h00, uio_out}, 16'h0040);
        check("prev result while busy", {8'h00, uo_out}, 16'h0010);
        repeat (2) @(negedge clk);
        ui_in  = 8'd2;
        uio_in = 8'h02;
        @(negedge clk);
        ui_in  = 8'd7;
        uio_in = 8'h01;
        @(negedge clk);
        ui_in  = 8'h00;
        uio_in = 8'h00;
        wait_done(4, cyc);
        check_result("ignore while busy", cyc, 8);

        // Back-to-back start on the cycle after done; A must still be 3.
        issue_start(8'd1, 1'b0, 16'h0003);
        #1;
        check("b2b prev result lo", {8'h00, uo_out}, 16'h000F);
        wait_done(0, cyc);
        check_result("back to back", cyc, 8);
        @(negedge clk);

        // Reset mid-operation aborts.
        load_a(8'd9);
        issue_start(8'd9, 1'b0, 16'h0051);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_front());
        check("abort flags", {8'h00, uio_out}, 16'h0000);
        check("abort result lo", {8'h00, uo_out}, 16'h0000);
        uio_in = 8'h04;
        #1;
        check("abort result hi", {8'h00, uo_out}, 16'h0000);
        uio_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after abort", 8'd7, 8'd6, 1'b0, 16'h002A);

        // ena low for 3 cycles stretches latency by 3.
        load_a(8'd11);
        issue_start(8'd10, 1'b0, 16'h006E);
        repeat (2) @(negedge clk);
        ena = 1'b0;
        repeat (3) @(negedge clk);
        check("frozen busy", {8'h00, uio_out}, 16'h0040);
        ena = 1'b1;
        wait_done(5, cyc);
        check_result("ena stall", cyc, 11);

        check("scoreboard drained", 16'(exp_q.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
